// File: rtl/cpsum_axis_serializer_if.sv
// AXI4-Stream bundle for the partial-sum serializer output.
// Optional macro CPSUM_FRAME_ID_EN adds an 8-bit tuser carrying the frame id.
interface cpsum_axis_serializer_if #(
    parameter int unsigned DATA_W = 64
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
`ifdef CPSUM_FRAME_ID_EN
    logic [7:0]        tuser;
`endif

`ifdef CPSUM_FRAME_ID_EN
    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
`else
    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

// File: rtl/cpsum_axis_serializer.sv
// Captures the full-width partial-sum vector on each finish pulse, buffers up to FRAME_DEPTH
// frames and streams each out as ceil(IN_W/DATA_W) AXIS beats with tlast on the final beat.
// Optional macro CPSUM_FRAME_ID_EN adds a per-frame 8-bit sequence id on m_axis.tuser.
module cpsum_axis_serializer #(
    parameter int unsigned IN_W        = 19712,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned FRAME_DEPTH = 2,
    localparam int unsigned CNT_W      = $clog2(FRAME_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       i_data,
    input  logic                  i_valid,
    cpsum_axis_serializer_if.master m_axis,
    output logic [CNT_W-1:0]      o_frame_cnt,
    output logic                  o_full,
    output logic                  o_overflow,
    input  logic                  i_ovf_clr,
    output logic [15:0]           o_drop_cnt
);
    localparam int unsigned BEATS  = (IN_W + DATA_W - 1) / DATA_W;
    localparam int unsigned PAD_W  = BEATS * DATA_W;
    localparam int unsigned PTR_W  = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] BeatLast = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  CntFull  = CNT_W'(FRAME_DEPTH);

    // Power-of-two depth wraps naturally; a single slot never moves its pointer.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (FRAME_DEPTH == 1) ? '0 : p + PTR_W'(1);
    endfunction

    logic [IN_W-1:0]   slot_q [FRAME_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              tvalid;
    logic              hs;
    logic              last_hs;
    logic              accept;
    logic              drop;
    logic [PAD_W-1:0]  rd_pad;
    logic [DATA_W-1:0] beat_word;

`ifdef CPSUM_FRAME_ID_EN
    logic [7:0] slot_id_q [FRAME_DEPTH];
    logic [7:0] id_q, id_d;
`endif

    assign tvalid = (count_q != '0);

    // Next-state: handshake/accept decode, pointer, beat, occupancy and drop accounting.
    always_comb begin
        hs         = tvalid && m_axis.tready;
        last_hs    = hs && (beat_q == BeatLast);
        // A full buffer can still accept when the reading slot frees up this very cycle.
        accept     = i_valid && ((count_q < CntFull) || last_hs);
        drop       = i_valid && !accept;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_d     = beat_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
`ifdef CPSUM_FRAME_ID_EN
        id_d       = id_q;
`endif
        if (hs) begin
            beat_d = last_hs ? '0 : beat_q + BEAT_W'(1);
        end
        if (last_hs) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (accept) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
`ifdef CPSUM_FRAME_ID_EN
            id_d     = id_q + 8'd1;
`endif
        end
        unique case ({accept, last_hs})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Clear wins over a simultaneous drop; that drop goes unrecorded.
        if (i_ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
`ifdef CPSUM_FRAME_ID_EN
            id_q       <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_q     <= beat_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef CPSUM_FRAME_ID_EN
            id_q       <= id_d;
`endif
        end
    end

    // Frame storage; contents are not reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_q[wr_ptr_q] <= i_data;
`ifdef CPSUM_FRAME_ID_EN
            slot_id_q[wr_ptr_q] <= id_q;
`endif
        end
    end

    // Beat select from the zero-padded read slot so the tail of the last beat is 0.
    always_comb begin
        rd_pad            = '0;
        rd_pad[IN_W-1:0]  = slot_q[rd_ptr_q];
        beat_word         = rd_pad[beat_q * DATA_W +: DATA_W];
    end

    assign m_axis.tvalid = tvalid;
    assign m_axis.tdata  = tvalid ? beat_word : '0;
    assign m_axis.tlast  = tvalid && (beat_q == BeatLast);
`ifdef CPSUM_FRAME_ID_EN
    assign m_axis.tuser  = tvalid ? slot_id_q[rd_ptr_q] : '0;
`endif

    assign o_frame_cnt = count_q;
    assign o_full      = (count_q == CntFull);
    assign o_overflow  = overflow_q;
    assign o_drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_cpsum_axis_serializer.sv
// Scoreboard bench for cpsum_axis_serializer (IN_W=200, DATA_W=64, FRAME_DEPTH=2).
module tb_cpsum_axis_serializer;
    localparam int unsigned IN_W        = 200;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned FRAME_DEPTH = 2;
    localparam int unsigned CNT_W       = $clog2(FRAME_DEPTH + 1);
    localparam int unsigned BEATS       = (IN_W + DATA_W - 1) / DATA_W;
    localparam int unsigned PAD_W       = BEATS * DATA_W;
    localparam int unsigned RW          = ((IN_W + 31) / 32) * 32;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [7:0]        id;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  i_data;
    logic             i_valid;
    logic             i_ovf_clr;
    logic [CNT_W-1:0] o_frame_cnt;
    logic             o_full;
    logic             o_overflow;
    logic [15:0]      o_drop_cnt;

    cpsum_axis_serializer_if #(.DATA_W(DATA_W)) axis ();

    cpsum_axis_serializer #(
        .IN_W       (IN_W),
        .DATA_W     (DATA_W),
        .FRAME_DEPTH(FRAME_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .m_axis     (axis),
        .o_frame_cnt(o_frame_cnt),
        .o_full     (o_full),
        .o_overflow (o_overflow),
        .i_ovf_clr  (i_ovf_clr),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    fq_n   = 0;   // frames held by the reference buffer
    int    mbeat  = 0;   // beat index within the head frame
    logic        m_ovf = 1'b0;
    logic [15:0] m_dc  = '0;
    logic [7:0]  m_id  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W-1:0] rand_data();
        logic [RW-1:0] t;
        for (int i = 0; i < RW / 32; i++) t[i*32 +: 32] = $urandom;
        return t[IN_W-1:0];
    endfunction

    // Reference model: buffer as a frame count plus a queue of expected beats.
    initial forever begin
        bit hs, last_hs, acc, drop;
        logic [PAD_W-1:0] pad;
        beat_t bt;
        @(posedge clk or negedge rst);
        if (!rst) begin
            exp_q.delete();
            fq_n  = 0;
            mbeat = 0;
            m_ovf = 1'b0;
            m_dc  = '0;
            m_id  = '0;
        end else begin
            hs      = (fq_n > 0) && (axis.tready === 1'b1);
            last_hs = hs && (mbeat == BEATS - 1);
            acc     = (i_valid === 1'b1) && ((fq_n < FRAME_DEPTH) || last_hs);
            drop    = (i_valid === 1'b1) && !acc;
            if (hs) begin
                if (last_hs) begin
                    mbeat = 0;
                    fq_n--;
                end else begin
                    mbeat++;
                end
            end
            if (acc) begin
                pad = '0;
                pad[IN_W-1:0] = i_data;
                for (int b = 0; b < BEATS; b++) begin
                    bt.data = pad[b*DATA_W +: DATA_W];
                    bt.last = (b == BEATS - 1);
                    bt.id   = m_id;
                    exp_q.push_back(bt);
                end
                m_id = m_id + 8'd1;
                fq_n++;
            end
            if (i_ovf_clr) begin
                m_ovf = 1'b0;
                m_dc  = '0;
            end else if (drop) begin
                m_ovf = 1'b1;
                if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
            end
        end
    end

    // Monitor: compares DUT outputs against the head of the scoreboard every cycle.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("tvalid", axis.tvalid, fq_n != 0);
            check("frame_cnt", o_frame_cnt, fq_n);
            check("full", o_full, fq_n == FRAME_DEPTH);
            check("overflow", o_overflow, m_ovf);
            check("drop_cnt", o_drop_cnt, m_dc);
            if (axis.tvalid === 1'b1) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("tdata", axis.tdata, exp_q[0].data);
                    check("tlast", axis.tlast, exp_q[0].last);
`ifdef CPSUM_FRAME_ID_EN
                    check("tuser", axis.tuser, exp_q[0].id);
`endif
                    if (axis.tready === 1'b1) void'(exp_q.pop_front());
                end
            end else begin
                check("tlast_idle", axis.tlast, 0);
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        axis.tready = 1'b1;
        while (fq_n != 0 && n < 200) begin
            tick();
            n++;
        end
        check(name, fq_n, 0);
    endtask

    initial begin
        logic [IN_W-1:0] pat;
        rst         = 1'b0;
        i_data      = '0;
        i_valid     = 1'b0;
        i_ovf_clr   = 1'b0;
        axis.tready = 1'b0;
        repeat (2) tick();
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tlast", axis.tlast, 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_frame_cnt", o_frame_cnt, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_drop_cnt", o_drop_cnt, 0);
        rst = 1'b1;
        tick();

        // Byte-ramp frame, free-flowing sink; tvalid one cycle after the strobe.
        for (int k = 0; k < IN_W / 8; k++) pat[k*8 +: 8] = 8'(k);
        axis.tready = 1'b1;
        i_data  = pat;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("latency_tvalid", axis.tvalid, 1);
        repeat (6) tick();

        // Backpressure 1,0,0,1 pattern.
        i_data  = rand_data();
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            axis.tready = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        drain("bp_drain");

        // Three strobes with a stalled sink: two stored, one dropped.
        axis.tready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = rand_data();
            tick();
        end
        i_valid = 1'b0;
        check("ovf_full", o_full, 1);
        check("ovf_flag", o_overflow, 1);
        check("ovf_drop_cnt", o_drop_cnt, 1);
        drain("ovf_drain");

        // Full buffer, capture coincident with last-beat handshake.
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        axis.tready = 1'b0;
        i_valid = 1'b1;
        i_data = rand_data();
        tick();
        i_data = rand_data();
        tick();
        i_valid = 1'b0;
        axis.tready = 1'b1;
        repeat (3) tick();
        i_data  = rand_data();
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("coinc_frame_cnt", o_frame_cnt, 2);
        check("coinc_overflow", o_overflow, 0);
        drain("coinc_drain");

        // Reset in the middle of a frame.
        i_data  = rand_data();
        i_valid = 1'b1;
        axis.tready = 1'b1;
        tick();
        i_valid = 1'b0;
        axis.tready = 1'b0;
        repeat (2) tick();
        axis.tready = 1'b1;
        tick();
        #2 rst = 1'b0;
        #1;
        check("midrst_tvalid", axis.tvalid, 0);
        check("midrst_tdata", axis.tdata, 0);
        check("midrst_frame_cnt", o_frame_cnt, 0);
        tick();
        rst = 1'b1;
        tick();
        i_data  = rand_data();
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        drain("midrst_drain");

        // Randomized traffic long enough to wrap the frame id.
        for (int i = 0; i < 2500; i++) begin
            i_valid     = ($urandom_range(0, 9) < 3);
            i_data      = rand_data();
            axis.tready = ($urandom_range(0, 3) != 0);
            i_ovf_clr   = ($urandom_range(0, 49) == 0);
            tick();
        end
        i_valid   = 1'b0;
        i_ovf_clr = 1'b0;
        drain("rand_drain");
        tick();
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
